// File: rtl/demultiplexor_tdm_1a4.sv
// Splits a 4-slot TDM beat stream back into four registered lanes, locking on the SYNC marker.
// Latency: lanes/FRAME_VALID/FRAME_CNT update on the edge that samples the slot-3 beat; ERR on the offending SYNC edge.
// Backpressure: none; every D_VALID beat is consumed the cycle it is presented.
module demultiplexor_tdm_1a4 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    input  logic             SYNC,
    output logic [WIDTH-1:0] L0,
    output logic [WIDTH-1:0] L1,
    output logic [WIDTH-1:0] L2,
    output logic [WIDTH-1:0] L3,
    output logic [1:0]       SEL,
    output logic             LOCKED,
    output logic             FRAME_VALID,
    output logic             ERR,
    output logic [CNT_W-1:0] FRAME_CNT
);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t           state;
    logic [WIDTH-1:0] s0, s1, s2;

    assign LOCKED = (state == LOCK);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= HUNT;
            SEL         <= 2'd0;
            s0          <= '0;
            s1          <= '0;
            s2          <= '0;
            L0          <= '0;
            L1          <= '0;
            L2          <= '0;
            L3          <= '0;
            FRAME_VALID <= 1'b0;
            ERR         <= 1'b0;
            FRAME_CNT   <= '0;
        end else begin
            FRAME_VALID <= 1'b0;
            ERR         <= 1'b0;
            if (D_VALID) begin
                case (state)
                    HUNT: begin
                        // Unsynchronised beats are dropped until the first marker.
                        if (SYNC) begin
                            s0    <= D;
                            SEL   <= 2'd1;
                            state <= LOCK;
                        end
                    end
                    LOCK: begin
                        if (SYNC && SEL != 2'd0) begin
                            // Marker inside a frame: drop the partial frame and restart at slot 1.
                            ERR <= 1'b1;
                            s0  <= D;
                            SEL <= 2'd1;
                        end else begin
                            case (SEL)
                                2'd0: s0 <= D;
                                2'd1: s1 <= D;
                                2'd2: s2 <= D;
                                default: begin
                                    L0          <= s0;
                                    L1          <= s1;
                                    L2          <= s2;
                                    L3          <= D;
                                    FRAME_VALID <= 1'b1;
                                    FRAME_CNT   <= FRAME_CNT + CNT_W'(1);
                                end
                            endcase
                            SEL <= SEL + 2'd1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
